// File: rtl/latch_stim_pkg.sv
// Shared types and default constants for the latch stimulus sequencer.
// Counter width and the fallback values used when a config field is zero.
package latch_stim_pkg;

  localparam int STIM_CNT_W      = 21;
  localparam int STIM_DEF_D_HALF = 401;
  localparam int STIM_DEF_G_HALF = 200;
  localparam int STIM_DEF_BUDGET = 4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stim_state_t;

endpackage

// File: rtl/latch_stim_gen_toggler.sv
// Square-wave generator: registered output flips each time the count reaches half-1.
// Output changes 1 clk after the qualifying edge; no backpressure, en simply pauses the wave.
module half_period_toggler #(
  parameter int CNT_W = latch_stim_pkg::STIM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] half,
  input  logic             init_val,
  output logic             out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] last_cnt;

  // half==1 gives last_cnt==0, so the wave flips every enabled cycle
  assign last_cnt = half - CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (clr) begin
      cnt_d = '0;
      out_d = init_val;
    end else if (en) begin
      if (cnt_q == last_cnt) begin
        cnt_d = '0;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/latch_stim_gen.sv
// Drives latch D and gate as two independent square waves for a bounded run, with start/stop control.
// start -> busy is 1 clk, last RUN cycle -> done is 1 clk; no backpressure.
module latch_stim_gen
  import latch_stim_pkg::*;
#(
  parameter int CNT_W      = STIM_CNT_W,
  parameter int DEF_D_HALF = STIM_DEF_D_HALF,
  parameter int DEF_G_HALF = STIM_DEF_G_HALF,
  parameter int DEF_BUDGET = STIM_DEF_BUDGET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] d_half_period,
  input  logic [CNT_W-1:0] g_half_period,
  input  logic [CNT_W-1:0] budget,
  output logic             d_out,
  output logic             g_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] elapsed
);

  stim_state_t      state_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] d_half_q, g_half_q, budget_q, elapsed_q;
  logic [CNT_W-1:0] d_half_d, g_half_d, budget_d;
  logic             start_acc, run_en, budget_hit;

  // stop outranks start when idle, and outranks budget expiry while running
  assign start_acc  = (state_q != RUN) && start && !stop;
  assign run_en     = (state_q == RUN) && !stop;
  assign budget_hit = (elapsed_q == budget_q - CNT_W'(1));

  assign d_half_d = (d_half_period == '0) ? CNT_W'(DEF_D_HALF) : d_half_period;
  assign g_half_d = (g_half_period == '0) ? CNT_W'(DEF_G_HALF) : g_half_period;
  assign budget_d = (budget == '0)        ? CNT_W'(DEF_BUDGET) : budget;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      elapsed_q <= '0;
      d_half_q  <= '0;
      g_half_q  <= '0;
      budget_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_acc) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            elapsed_q <= '0;
            d_half_q  <= d_half_d;
            g_half_q  <= g_half_d;
            budget_q  <= budget_d;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            elapsed_q <= elapsed_q + CNT_W'(1);
            if (budget_hit) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  half_period_toggler #(.CNT_W(CNT_W)) u_d_wave (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc),
    .en       (run_en),
    .half     (d_half_q),
    .init_val (1'b0),
    .out      (d_out)
  );

  half_period_toggler #(.CNT_W(CNT_W)) u_g_wave (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc),
    .en       (run_en),
    .half     (g_half_q),
    .init_val (1'b1),
    .out      (g_out)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_latch_stim_gen.sv
// Scoreboarded random/directed bench: expected waves come from closed-form half-period arithmetic.
module tb_latch_stim_gen;

  localparam int CNT_W = 21;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop;
  logic [CNT_W-1:0] d_half_period, g_half_period, budget;
  logic             d_out, g_out, busy, done;
  logic [CNT_W-1:0] elapsed;

  latch_stim_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .d_half_period (d_half_period),
    .g_half_period (g_half_period),
    .budget        (budget),
    .d_out         (d_out),
    .g_out         (g_out),
    .busy          (busy),
    .done          (done),
    .elapsed       (elapsed)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fin;
    bit          d;
    bit          g;
    int unsigned el;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e, hold_e;
  bit   done_seen = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Wave value after k completed RUN cycles: level index is k/half, d starts low, g starts high
  function automatic bit d_ref(input int k, input int h);
    return ((k / h) % 2) == 1;
  endfunction

  function automatic bit g_ref(input int k, input int h);
    return ((k / h) % 2) == 0;
  endfunction

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      chk("busy_done_excl", 32'(done), 32'd0);
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: busy with no expected entry at %0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        checks++;
        if (mon_e.fin) begin
          failures++;
          $display("FAIL run_len: busy still 1, expected done with elapsed %0d (got elapsed %0d)", mon_e.el, elapsed);
        end
        chk("run_elapsed", 32'(elapsed), mon_e.el);
        chk("run_d_out", 32'(d_out), 32'(mon_e.d));
        chk("run_g_out", 32'(g_out), 32'(mon_e.g));
      end
    end else if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: done with no expected entry at %0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        checks++;
        if (!mon_e.fin) begin
          failures++;
          $display("FAIL early_done: done at elapsed %0d, expected busy at elapsed %0d", elapsed, mon_e.el);
        end
        chk("done_elapsed", 32'(elapsed), mon_e.el);
        chk("done_d_out", 32'(d_out), 32'(mon_e.d));
        chk("done_g_out", 32'(g_out), 32'(mon_e.g));
        hold_e = mon_e;
      end
    end else if (done === 1'b1) begin
      chk("hold_elapsed", 32'(elapsed), hold_e.el);
      chk("hold_d_out", 32'(d_out), 32'(hold_e.d));
      chk("hold_g_out", 32'(g_out), 32'(hold_e.g));
    end
    if (done !== 1'b1) done_seen = 1'b0;
  end

  task automatic scramble_cfg();
    d_half_period = CNT_W'($urandom);
    g_half_period = CNT_W'($urandom);
    budget        = CNT_W'($urandom);
  endtask

  // stop_at / start_at / rst_at are RUN-cycle indices (elapsed value during that cycle), -1 = none
  task automatic do_run(input int hd, input int hg, input int b,
                        input int stop_at, input int start_at, input int rst_at);
    int   ehd, ehg, eb, n_obs, kend;
    bit   fin_done;
    exp_t e;
    ehd = (hd == 0) ? 401 : hd;
    ehg = (hg == 0) ? 200 : hg;
    eb  = (b == 0) ? 4000 : b;
    n_obs = eb;
    if (stop_at >= 0) n_obs = stop_at + 1;
    if (rst_at >= 0)  n_obs = rst_at + 1;
    for (int k = 0; k < n_obs; k++) begin
      e.fin = 1'b0; e.d = d_ref(k, ehd); e.g = g_ref(k, ehg); e.el = k;
      sbq.push_back(e);
    end
    if (rst_at < 0) begin
      kend = (stop_at >= 0) ? stop_at : eb;
      e.fin = 1'b1; e.d = d_ref(kend, ehd); e.g = g_ref(kend, ehg); e.el = kend;
      sbq.push_back(e);
    end

    d_half_period = CNT_W'(hd);
    g_half_period = CNT_W'(hg);
    budget        = CNT_W'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_cfg();

    fin_done = 1'b0;
    for (int c = 0; c < eb + 8 && !fin_done; c++) begin
      if (c == stop_at) stop = 1'b1;
      if (c == start_at) begin
        start = 1'b1;
        scramble_cfg();
      end
      if (c == rst_at) rst_n = 1'b0;
      @(posedge clk); #1;
      stop  = 1'b0;
      start = 1'b0;
      if (c == rst_at) begin
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        chk("rst_g_out", 32'(g_out), 32'd0);
        chk("rst_elapsed", 32'(elapsed), 32'd0);
        fin_done = 1'b1;
      end else if (done === 1'b1) begin
        fin_done = 1'b1;
      end
    end
    if (!fin_done) begin
      checks++; failures++;
      $display("FAIL run_timeout: no done after %0d cycles (elapsed %0d)", eb + 8, elapsed);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int hd, hg, b, sa, ta;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    d_half_period = '0; g_half_period = '0; budget = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_d_out", 32'(d_out), 32'd0);
    chk("init_g_out", 32'(g_out), 32'd0);
    chk("init_elapsed", 32'(elapsed), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start+stop together while idle: must not launch
    start = 1'b1; stop = 1'b1; scramble_cfg();
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("idle_startstop_busy", 32'(busy), 32'd0);
    chk("idle_startstop_done", 32'(done), 32'd0);

    do_run(3, 2, 10, -1, -1, -1);
    do_run(0, 0, 0, -1, -1, -1);
    do_run(1, 1, 50, 6, -1, -1);
    do_run(2, 3, 12, 11, -1, -1);
    do_run(4, 3, 20, -1, 5, -1);

    // start+stop together while done: stays done, monitor confirms frozen outputs
    start = 1'b1; stop = 1'b1; scramble_cfg();
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("done_startstop_busy", 32'(busy), 32'd0);
    chk("done_startstop_done", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    do_run(5, 1, 15, -1, -1, -1);
    do_run(1, 7, 1, -1, -1, -1);
    do_run(2, 2, 30, -1, -1, 9);
    do_run(6, 0, 25, -1, -1, -1);

    for (int i = 0; i < 40; i++) begin
      hd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      hg = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      b  = int'($urandom_range(1, 60));
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, b - 1)) : -1;
      ta = (b > 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, b - 2)) : -1;
      if (ta == sa) ta = -1;
      do_run(hd, hg, b, sa, ta, -1);
    end

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
